// File: rtl/mem_arb_pkg.sv
// Shared constants for the memory-port arbiter: FSM state encoding, owner
// identifiers and the latency counter width.
package mem_arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    localparam int CNT_W = 4;

endpackage

// File: rtl/arb_lat_counter.sv
// Loadable down-counter with a zero flag; times the BUSY phase of a memory
// access.
module arb_lat_counter
    import mem_arb_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Sequencer for the shared memory port: arbitrates IF vs DM, times a
// fixed-latency access, captures read data and pulses done to the owner.
// Optional feature macro: ARB_RR_EN (round-robin tie-break instead of DM priority).
//
// Handshake: x_req is a level held until x_done; the one-cycle x_done pulse
// marks completion and the requester may change x_req on the edge ending it.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_sel,
    output logic              mem_en,
    output logic              mem_we,
    output logic [DATA_W-1:0] rdata,
    output logic              if_done,
    output logic              dm_done,
    output logic              if_stall,
    output logic              dm_stall,
    output logic [1:0]        dbg_state
);

    if (MEM_LAT < 1 || MEM_LAT > 15 || ADDR_W < 1) begin : g_param_check
        $error("mem_port_arbiter: MEM_LAT must be 1..15 and ADDR_W positive");
    end

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

    logic [1:0]        state_q, state_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              if_done_q, if_done_d;
    logic              dm_done_q, dm_done_d;
    logic              tie_winner;
    logic              cnt_load;
    logic              cnt_dec;
    logic              cnt_zero;

`ifdef ARB_RR_EN
    logic last_owner_q, last_owner_d;

    // On a tie the requester that did not win last time goes first.
    assign tie_winner = (last_owner_q == OWN_IF) ? OWN_DM : OWN_IF;
`else
    // The data access belongs to the older instruction, so it wins ties.
    assign tie_winner = OWN_DM;
`endif

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        we_d     = we_q;
        rdata_d  = rdata_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
`ifdef ARB_RR_EN
        last_owner_d = last_owner_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (if_req || dm_req) begin
                    if (if_req && dm_req) begin
                        owner_d = tie_winner;
                    end else begin
                        owner_d = dm_req ? OWN_DM : OWN_IF;
                    end
                    we_d     = dm_we && (owner_d == OWN_DM);
                    cnt_load = 1'b1;
                    state_d  = ST_BUSY;
`ifdef ARB_RR_EN
                    last_owner_d = owner_d;
`endif
                end
            end
            ST_BUSY: begin
                if (cnt_zero) begin
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = ST_DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs toward memory and the requesters are registered from next-state.
    always_comb begin
        mem_en_d  = (state_d == ST_BUSY);
        mem_we_d  = (state_d == ST_BUSY) && we_d;
        if_done_d = (state_d == ST_DONE) && (owner_d == OWN_IF);
        dm_done_d = (state_d == ST_DONE) && (owner_d == OWN_DM);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_IF;
            we_q      <= 1'b0;
            mem_en_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            rdata_q   <= '0;
            if_done_q <= 1'b0;
            dm_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            mem_en_q  <= mem_en_d;
            mem_we_q  <= mem_we_d;
            rdata_q   <= rdata_d;
            if_done_q <= if_done_d;
            dm_done_q <= dm_done_d;
        end
    end

`ifdef ARB_RR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_owner_q <= OWN_IF;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end
`endif

    arb_lat_counter #(
        .W(CNT_W)
    ) u_lat_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (LAT_LOAD),
        .zero     (cnt_zero)
    );

    assign mem_sel   = owner_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign rdata     = rdata_q;
    assign if_done   = if_done_q;
    assign dm_done   = dm_done_q;
    assign if_stall  = if_req & ~if_done_q;
    assign dm_stall  = dm_req & ~dm_done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: reset abort, table-driven single
// transactions, held ties, randomized traffic vs a transaction model, MEM_LAT=1.
module tb_mem_port_arbiter;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic        mem_sel, mem_en, mem_we, if_done, dm_done, if_stall, dm_stall;
    logic [15:0] rdata;
    logic [1:0]  dbg_state;

    logic        if_req1 = 1'b0, dm_req1 = 1'b0, dm_we1 = 1'b0;
    logic [15:0] mem_rdata1 = '0;
    logic        mem_sel1, mem_en1, mem_we1, if_done1, dm_done1, if_stall1, dm_stall1;
    logic [15:0] rdata1;
    logic [1:0]  dbg_state1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(L)) dut (
        .clk(clk), .reset(reset), .if_req(if_req), .dm_req(dm_req), .dm_we(dm_we),
        .mem_rdata(mem_rdata), .mem_sel(mem_sel), .mem_en(mem_en), .mem_we(mem_we),
        .rdata(rdata), .if_done(if_done), .dm_done(dm_done), .if_stall(if_stall),
        .dm_stall(dm_stall), .dbg_state(dbg_state)
    );

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .if_req(if_req1), .dm_req(dm_req1), .dm_we(dm_we1),
        .mem_rdata(mem_rdata1), .mem_sel(mem_sel1), .mem_en(mem_en1), .mem_we(mem_we1),
        .rdata(rdata1), .if_done(if_done1), .dm_done(dm_done1), .if_stall(if_stall1),
        .dm_stall(dm_stall1), .dbg_state(dbg_state1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transaction-level model: an access is described by its age in edges
    // since the grant; BUSY spans ages 1..L, the done cycle is age L+1.
    bit          m_active;
    int          m_age;
    bit          m_owner;
    bit          m_we;
    logic [15:0] m_rdata;
    bit          m_last;

    task automatic model_reset();
        m_active = 0; m_age = 0; m_owner = 0; m_we = 0; m_rdata = '0; m_last = 0;
    endtask

    task automatic model_step();
        bit w;
        if (!m_active) begin
            if (if_req || dm_req) begin
                if (if_req && dm_req) begin
`ifdef ARB_RR_EN
                    w = !m_last;
`else
                    w = 1'b1;
`endif
                end else begin
                    w = dm_req;
                end
                m_owner = w; m_we = dm_we && w; m_last = w;
                m_active = 1; m_age = 1;
            end
        end else begin
            if (m_age == L && !m_we) m_rdata = mem_rdata;
            m_age++;
            if (m_age == L + 2) m_active = 0;
        end
    endtask

    // Per-cycle driver values and observations.
    logic        if_req_v = 0, dm_req_v = 0, dm_we_v = 0;
    logic [15:0] rdata_v = '0;
    logic        obs_sel, obs_en, obs_we, obs_ifd, obs_dmd;
    logic [15:0] obs_rdata;
    bit          prev_ifd, prev_dmd;

    task automatic cycle();
        bit e_en, e_we, e_ifd, e_dmd;
        logic [22:0] act, exp;
        @(negedge clk);
        if_req = if_req_v; dm_req = dm_req_v; dm_we = dm_we_v; mem_rdata = rdata_v;
        #1;
        e_en  = m_active && (m_age <= L);
        e_we  = e_en && m_we;
        e_ifd = m_active && (m_age == L + 1) && !m_owner;
        e_dmd = m_active && (m_age == L + 1) && m_owner;
        exp = {m_owner, e_en, e_we, e_ifd, e_dmd, if_req & ~e_ifd, dm_req & ~e_dmd, m_rdata};
        act = {mem_sel, mem_en, mem_we, if_done, dm_done, if_stall, dm_stall, rdata};
        check("cycle_outputs", 64'(act), 64'(exp));
        obs_sel = mem_sel; obs_en = mem_en; obs_we = mem_we;
        obs_ifd = if_done; obs_dmd = dm_done; obs_rdata = rdata;
        prev_ifd = e_ifd; prev_dmd = e_dmd;
        @(posedge clk);
        model_step();
    endtask

    typedef struct {
        logic        if_r;
        logic        dm_r;
        logic        we;
        logic [15:0] data;
        logic        exp_sel;
        logic        exp_we;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int dm_done_cnt;
        int n_calls;
        bit got_done, got_sel;
        logic cap_sel, cap_we;
        logic exp_owner[3];
        logic got_owner[$];
        int done_at[$];

        tbl[0] = '{1'b1, 1'b0, 1'b0, 16'hBEEF, 1'b0, 1'b0, 16'hBEEF};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 16'h1111, 1'b1, 1'b1, 16'hBEEF};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 16'h5A5A, 1'b1, 1'b0, 16'h5A5A};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 16'h0F0F, 1'b0, 1'b0, 16'h0F0F};
        // last winner was IF, so DM wins this tie in both builds
        tbl[4] = '{1'b1, 1'b1, 1'b0, 16'h1234, 1'b1, 1'b0, 16'h1234};
`ifdef ARB_RR_EN
        tbl[5] = '{1'b1, 1'b1, 1'b1, 16'h7777, 1'b0, 1'b0, 16'h7777};
`else
        tbl[5] = '{1'b1, 1'b1, 1'b1, 16'h7777, 1'b1, 1'b1, 16'h1234};
`endif
        tbl[6] = '{1'b1, 1'b0, 1'b1, 16'h4321, 1'b0, 1'b0, 16'h4321};

        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_vals", 64'({dbg_state, mem_sel, mem_en, mem_we, if_done, dm_done, rdata}), 64'(0));
        check("reset_vals_lat1", 64'({dbg_state1, mem_sel1, mem_en1, mem_we1, if_done1, dm_done1, rdata1}), 64'(0));

        // Reset in the middle of a DM write aborts it without a done pulse.
        dm_req_v = 1; dm_we_v = 1; rdata_v = 16'hDEAD;
        cycle();
        cycle();
        #2 reset = 1'b1;
        #1;
        check("reset_mid_busy", 64'({mem_sel, mem_en, mem_we, if_done, dm_done, rdata}), 64'(0));
        model_reset();
        dm_req_v = 0; dm_we_v = 0; dm_req = 0; dm_we = 0;
        @(negedge clk);
        reset = 1'b0;
        dm_done_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (obs_dmd) dm_done_cnt++;
        end
        check("no_done_after_reset", 64'(dm_done_cnt), 64'(0));
        check("rdata_after_reset", 64'(obs_rdata), 64'(0));

        // Table of single transactions, each started from IDLE.
        for (int t = 0; t < 7; t++) begin
            if_req_v = tbl[t].if_r; dm_req_v = tbl[t].dm_r; dm_we_v = tbl[t].we;
            rdata_v = tbl[t].data;
            got_done = 0; got_sel = 0; n_calls = 0; cap_sel = 0; cap_we = 0;
            for (int c = 0; c < 12 && !got_done; c++) begin
                cycle();
                n_calls++;
                if (obs_en && !got_sel) begin
                    got_sel = 1; cap_sel = obs_sel; cap_we = obs_we;
                end
                if (obs_ifd || obs_dmd) got_done = 1;
            end
            if (!got_done) begin
                check("tbl_timeout", 64'(0), 64'(1));
            end else begin
                check("tbl_latency_edges", 64'(n_calls - 1), 64'(L + 1));
                check("tbl_sel", 64'(cap_sel), 64'(tbl[t].exp_sel));
                check("tbl_mem_we", 64'(cap_we), 64'(tbl[t].exp_we));
                check("tbl_done_owner", 64'({obs_ifd, obs_dmd}), 64'({~tbl[t].exp_sel, tbl[t].exp_sel}));
                check("tbl_rdata", 64'(obs_rdata), 64'(tbl[t].exp_rdata));
            end
            if_req_v = 0; dm_req_v = 0; dm_we_v = 0;
        end

        // Both requests held: three back-to-back transactions, period L+2.
`ifdef ARB_RR_EN
        exp_owner = '{1'b1, 1'b0, 1'b1};
`else
        exp_owner = '{1'b1, 1'b1, 1'b1};
`endif
        if_req_v = 1; dm_req_v = 1; dm_we_v = 0;
        for (int c = 0; c < 3 * (L + 2); c++) begin
            rdata_v = 16'($urandom);
            cycle();
            if (obs_ifd) begin got_owner.push_back(1'b0); done_at.push_back(c); end
            if (obs_dmd) begin got_owner.push_back(1'b1); done_at.push_back(c); end
        end
        check("tie_grant_count", 64'(got_owner.size()), 64'(3));
        for (int i = 0; i < 3 && i < got_owner.size(); i++)
            check("tie_grant_owner", 64'(got_owner[i]), 64'(exp_owner[i]));
        for (int i = 1; i < done_at.size(); i++)
            check("tie_period", 64'(done_at[i] - done_at[i-1]), 64'(L + 2));
        if_req_v = 0; dm_req_v = 0;

        // Randomized traffic: requests held until their done, then re-decided.
        prev_ifd = 0; prev_dmd = 0;
        for (int c = 0; c < 400; c++) begin
            if (prev_ifd || !if_req_v) if_req_v = ($urandom_range(0, 2) == 0);
            if (prev_dmd || !dm_req_v) begin
                dm_req_v = ($urandom_range(0, 2) == 0);
                dm_we_v = 1'($urandom_range(0, 1));
            end
            rdata_v = 16'($urandom);
            cycle();
        end
        if_req_v = 0; dm_req_v = 0; dm_we_v = 0;
        repeat (L + 3) cycle();

        // MEM_LAT = 1: IF read, DM raised during its BUSY cycle.
        @(negedge clk);
        if_req1 = 1; mem_rdata1 = 16'h1234;
        @(negedge clk);
        check("lat1_busy_en", 64'({mem_en1, mem_sel1, if_done1}), 64'(3'b100));
        dm_req1 = 1; dm_we1 = 0;
        @(negedge clk);
        check("lat1_if_done", 64'({mem_en1, if_done1, dm_stall1}), 64'(3'b011));
        check("lat1_rdata_if", 64'(rdata1), 64'(16'h1234));
        @(negedge clk);
        if_req1 = 0; mem_rdata1 = 16'hABCD;
        #1;
        check("lat1_dm_waits", 64'({mem_en1, mem_sel1, dm_done1, dm_stall1, if_stall1}), 64'(5'b00010));
        @(negedge clk);
        check("lat1_dm_grant", 64'({mem_en1, mem_sel1, mem_we1}), 64'(3'b110));
        @(negedge clk);
        check("lat1_dm_done", 64'({mem_en1, dm_done1, dm_stall1}), 64'(3'b010));
        check("lat1_rdata_dm", 64'(rdata1), 64'(16'hABCD));
        dm_req1 = 0;
        @(negedge clk);
        check("lat1_idle", 64'({mem_en1, dm_done1, if_done1}), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
